// File: rtl/ad7643_serial_reader.sv
// AD7643 conversion sequencer + 18-bit serial readout; `define AD7643_DUAL_EN adds a second data lane (ADSDOUT1/DOUT1).
// Latency: DVALID 2*SCLK_DIV*DATA_W+2 cycles after the first WAIT_L cycle that sees BUSY low.
// Backpressure: none; DVALID is a one-cycle strobe and DOUT holds until the next sample.
module ad7643_serial_reader #(
    parameter int SCLK_DIV     = 4,
    parameter int CNVST_LOW    = 3,
    parameter int BUSY_TIMEOUT = 255,
    parameter int DATA_W       = 18
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              CONT,
    input  logic              CLRERR,
    input  logic              ADBUSY,
    input  logic              ADSDOUT,
`ifdef AD7643_DUAL_EN
    input  logic              ADSDOUT1,
    output logic [DATA_W-1:0] DOUT1,
`endif
    output logic              ADCNVST,
    output logic              ADCS,
    output logic              ADSCLK,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    output logic              BUSYO,
    output logic              TOERR
);

    localparam int WW = $clog2(BUSY_TIMEOUT + 1);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CNV, S_WAIT_H, S_WAIT_L, S_SETUP, S_SHIFT, S_DONE
    } state_t;

    state_t            state;
    logic              bsy_m;
    logic              bsy_s;
    logic [7:0]        ph_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sreg;
`ifdef AD7643_DUAL_EN
    logic [DATA_W-1:0] sreg1;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            bsy_m    <= 1'b0;
            bsy_s    <= 1'b0;
            ph_cnt   <= '0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            ADCNVST  <= 1'b1;
            ADCS     <= 1'b1;
            ADSCLK   <= 1'b1;
            DOUT     <= '0;
            DVALID   <= 1'b0;
            BUSYO    <= 1'b0;
            TOERR    <= 1'b0;
`ifdef AD7643_DUAL_EN
            sreg1    <= '0;
            DOUT1    <= '0;
`endif
        end else begin
            bsy_m  <= ADBUSY;
            bsy_s  <= bsy_m;
            DVALID <= 1'b0;
            // A timeout below overrides this clear in the same cycle.
            if (CLRERR)
                TOERR <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (START || CONT) begin
                        ADCNVST <= 1'b0;
                        ph_cnt  <= '0;
                        BUSYO   <= 1'b1;
                        state   <= S_CNV;
                    end
                end
                S_CNV: begin
                    if (ph_cnt == 8'(CNVST_LOW - 1)) begin
                        ADCNVST  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_WAIT_H;
                    end else begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end
                end
                S_WAIT_H: begin
                    if (bsy_s) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT_L;
                    end else if (wait_cnt == WW'(BUSY_TIMEOUT - 1)) begin
                        TOERR <= 1'b1;
                        ADCS  <= 1'b1;
                        BUSYO <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_WAIT_L: begin
                    if (!bsy_s) begin
                        ADCS  <= 1'b0;
                        state <= S_SETUP;
                    end else if (wait_cnt == WW'(BUSY_TIMEOUT - 1)) begin
                        TOERR <= 1'b1;
                        ADCS  <= 1'b1;
                        BUSYO <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_SETUP: begin
                    ADSCLK  <= 1'b0;
                    ph_cnt  <= '0;
                    bit_cnt <= BW'(DATA_W - 1);
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ph_cnt == 8'(SCLK_DIV - 1)) begin
                        ph_cnt <= '0;
                        if (!ADSCLK) begin
                            // Data is captured on the edge that raises ADSCLK.
                            ADSCLK <= 1'b1;
                            sreg   <= {sreg[DATA_W-2:0], ADSDOUT};
`ifdef AD7643_DUAL_EN
                            sreg1  <= {sreg1[DATA_W-2:0], ADSDOUT1};
`endif
                        end else if (bit_cnt == '0) begin
                            ADCS   <= 1'b1;
                            DOUT   <= sreg;
`ifdef AD7643_DUAL_EN
                            DOUT1  <= sreg1;
`endif
                            DVALID <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            ADSCLK  <= 1'b0;
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (CONT) begin
                        ADCNVST <= 1'b0;
                        ph_cnt  <= '0;
                        state   <= S_CNV;
                    end else begin
                        BUSYO <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7643_serial_reader.sv
// Bench for ad7643_serial_reader: ADC behavioural model, scoreboard of expected samples, timing monitor.
module tb_ad7643_serial_reader;
    localparam int SCLK_DIV     = 2;
    localparam int CNVST_LOW    = 3;
    localparam int BUSY_TIMEOUT = 255;
    localparam int DATA_W       = 18;
    // Cycles from the first clock edge that sees ADBUSY low to DVALID: one extra synchroniser stage
    // on top of the 2*SCLK_DIV*DATA_W+2 counted from the synchronised fall.
    localparam int LAT    = 2 * SCLK_DIV * DATA_W + 3;
    localparam int CS_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start, cont, clrerr, adbusy, adsdout, adsdout1;
    logic adcnvst, adcs, adsclk, dvalid, busyo, toerr;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] dout1;

    ad7643_serial_reader #(
        .SCLK_DIV(SCLK_DIV), .CNVST_LOW(CNVST_LOW),
        .BUSY_TIMEOUT(BUSY_TIMEOUT), .DATA_W(DATA_W)
    ) dut (
        .CLK(clk), .RSTN(rstn), .START(start), .CONT(cont), .CLRERR(clrerr),
        .ADBUSY(adbusy), .ADSDOUT(adsdout),
`ifdef AD7643_DUAL_EN
        .ADSDOUT1(adsdout1), .DOUT1(dout1),
`endif
        .ADCNVST(adcnvst), .ADCS(adcs), .ADSCLK(adsclk), .DOUT(dout),
        .DVALID(dvalid), .BUSYO(busyo), .TOERR(toerr)
    );
`ifndef AD7643_DUAL_EN
    assign dout1 = '0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model state
    int busy_mode = 0;  // 0 normal pulse, 1 never rises, 2 rises and sticks high
    int busy_len  = 20;
    int since     = -1;
    int rises     = 0;
    logic prev_sclk  = 1'b1;
    logic prev_cnvst = 1'b1;
    logic [DATA_W-1:0] cur0 = '0;
    logic [DATA_W-1:0] cur1 = '0;
    logic [DATA_W-1:0] adc0[$];
    logic [DATA_W-1:0] adc1[$];
    logic [DATA_W-1:0] exp0[$];
    logic [DATA_W-1:0] exp1[$];

    always @(negedge clk) begin
        if (!rstn) begin
            since = -1; rises = 0; adbusy = 1'b0; adsdout = 1'b0; adsdout1 = 1'b0;
            prev_sclk = 1'b1; prev_cnvst = 1'b1;
        end else begin
            if (prev_cnvst && !adcnvst) begin
                since = 0;
                cur0 = (adc0.size() > 0) ? adc0.pop_front() : '0;
                cur1 = (adc1.size() > 0) ? adc1.pop_front() : '0;
            end
            prev_cnvst = adcnvst;
            if (since >= 0) begin
                case (busy_mode)
                    0:       adbusy = (since >= 2 && since < 2 + busy_len);
                    1:       adbusy = 1'b0;
                    default: adbusy = (since >= 2);
                endcase
                since++;
            end else begin
                adbusy = 1'b0;
            end
            if (adcs) rises = 0;
            else if (!prev_sclk && adsclk) rises++;
            prev_sclk = adsclk;
            adsdout  = (!adcs && rises < DATA_W) ? cur0[DATA_W-1-rises] : 1'b0;
            adsdout1 = (!adcs && rises < DATA_W) ? cur1[DATA_W-1-rises] : 1'b0;
        end
    end

    // Monitor / scoreboard
    int cyc = 0, fall_cyc = 0, cnv_w = 0, sclk_w = 0, pulses = 0, dv_cnt = 0;
    logic prev_bsy = 1'b0, prev_cs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            cnv_w = 0; sclk_w = 0; pulses = 0; prev_bsy = 1'b0; prev_cs = 1'b1;
        end else begin
            cyc++;
            if (prev_bsy && !adbusy) fall_cyc = cyc;
            prev_bsy = adbusy;
            if (!adcnvst) cnv_w++;
            else if (cnv_w != 0) begin
                check("cnvst_low_width", cnv_w, CNVST_LOW);
                cnv_w = 0;
            end
            if (!adsclk) sclk_w++;
            else if (sclk_w != 0) begin
                check("sclk_low_width", sclk_w, SCLK_DIV);
                pulses++;
                sclk_w = 0;
            end
            if (prev_cs && !adcs) check("adcs_fall_after_busy", cyc - fall_cyc, CS_LAT);
            if (dvalid) begin
                dv_cnt++;
                if (exp0.size() == 0) begin
                    check("unexpected_dvalid", 1, 0);
                end else begin
                    check("dout", dout, exp0.pop_front());
                    check("dout1", dout1, (exp1.size() > 0) ? exp1.pop_front() : '0);
                    check("dvalid_latency", cyc - fall_cyc, LAT);
                    check("sclk_pulses", pulses, DATA_W);
                    check("adcs_low_until_done", {prev_cs, adcs}, 2'b01);
                end
                pulses = 0;
            end
            prev_cs = adcs;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busyo && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busyo, 0);
    endtask

    task automatic wait_bit(input int b, input int budget);
        int n = 0;
        while (!(!adcs && rises >= b && rises < DATA_W) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit", n < budget, 1);
    endtask

    task automatic queue_sample(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1, input bit emit);
        adc0.push_back(d0);
        adc1.push_back(d1);
        if (emit) begin
            exp0.push_back(d0);
`ifdef AD7643_DUAL_EN
            exp1.push_back(d1);
`endif
        end
    endtask

    task automatic single(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int base = dv_cnt;
        queue_sample(d0, d1, 1'b1);
        pulse_start();
        wait_idle(2000);
        repeat (3) @(negedge clk);
        check("single_dvalid_count", dv_cnt - base, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_adcnvst", adcnvst, 1);
        check("rst_adcs", adcs, 1);
        check("rst_adsclk", adsclk, 1);
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_busyo", busyo, 0);
        check("rst_toerr", toerr, 0);
        check("rst_dout1", dout1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        rstn = 1'b1; start = 1'b0; cont = 1'b0; clrerr = 1'b0;
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single shot with the alternating pattern
        busy_mode = 0; busy_len = 20;
        single(18'h2AAAA, 18'h15555);
        check("busyo_after_single", busyo, 0);

        // Randomised single shots
        for (int i = 0; i < 5; i++) begin
            busy_len = $urandom_range(5, 40);
            single(DATA_W'($urandom), DATA_W'($urandom));
        end

        // Continuous: START and CONT together, CONT dropped during the third SHIFT
        busy_len = 20;
        base = dv_cnt;
        queue_sample(18'h00001, 18'h3FFFE, 1'b1);
        queue_sample(18'h3FFFF, 18'h00000, 1'b1);
        queue_sample(18'h20000, 18'h1FFFF, 1'b1);
        cont = 1'b1;
        pulse_start();
        n = 0;
        while (dv_cnt - base < 2 && n < 2000) begin @(negedge clk); n++; end
        check("cont_two_samples", dv_cnt - base, 2);
        wait_bit(3, 500);
        cont = 1'b0;
        wait_idle(2000);
        repeat (20) @(negedge clk);
        check("cont_three_samples", dv_cnt - base, 3);
        check("cont_busyo_low", busyo, 0);

        // Busy never rises: timeout from WAIT_H
        busy_mode = 1;
        base = dv_cnt;
        pulse_start();
        n = 0;
        while (!adcnvst && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!toerr && n < 1000) begin @(negedge clk); n++; end
        check("timeout_wait_h_cycles", n, BUSY_TIMEOUT);
        check("timeout_adcs", adcs, 1);
        check("timeout_busyo", busyo, 0);
        check("timeout_no_dvalid", dv_cnt - base, 0);
        clrerr = 1'b1;
        @(negedge clk);
        clrerr = 1'b0;
        check("toerr_cleared", toerr, 0);
        busy_mode = 0;
        single(DATA_W'($urandom), DATA_W'($urandom));

        // Busy stuck high: timeout from WAIT_L while CLRERR is held
        busy_mode = 2;
        base = dv_cnt;
        clrerr = 1'b1;
        pulse_start();
        n = 0;
        while (!toerr && n < 2000) begin @(negedge clk); n++; end
        clrerr = 1'b0;
        check("stuck_toerr_set_wins", toerr, 1);
        @(negedge clk);
        check("stuck_toerr_sticky", toerr, 1);
        check("stuck_busyo", busyo, 0);
        check("stuck_no_dvalid", dv_cnt - base, 0);
        busy_mode = 0;
        repeat (5) @(negedge clk);
        clrerr = 1'b1;
        @(negedge clk);
        clrerr = 1'b0;
        check("stuck_toerr_cleared", toerr, 0);

        // Reset in the middle of SHIFT
        base = dv_cnt;
        queue_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        pulse_start();
        wait_bit(9, 1000);
        rstn = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        check("reset_no_dvalid", dv_cnt - base, 0);
        single(DATA_W'($urandom), DATA_W'($urandom));

        // START pulsed during SHIFT is ignored
        base = dv_cnt;
        queue_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b1);
        pulse_start();
        wait_bit(4, 1000);
        pulse_start();
        wait_idle(2000);
        repeat (100) @(negedge clk);
        check("start_ignored_one_dvalid", dv_cnt - base, 1);
        check("start_ignored_idle", busyo, 0);

        check("scoreboard_drained", exp0.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
